// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: GPR and CSR operand forwarding from the producer stages,
// load-use stall detection with a saturating stall counter and a sticky
// timeout flag.
// Optional heap CSR shadow forwarding is built when HEAP_CSR_FWD_EN is defined.
module fwd_hazard_unit #(
    parameter int XLEN      = 64,
    parameter int NSTAGE    = 3,
    parameter int STALL_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid_i,
    input  logic [4:0]               rs1_addr_i,
    input  logic [4:0]               rs2_addr_i,
    input  logic [XLEN-1:0]          rs1_data_i,
    input  logic [XLEN-1:0]          rs2_data_i,
    input  logic [11:0]              csr_addr_i,
    input  logic [XLEN-1:0]          csr_data_i,
    input  logic [5*NSTAGE-1:0]      stg_rdaddr_i,
    input  logic [XLEN*NSTAGE-1:0]   stg_rddata_i,
    input  logic [NSTAGE-1:0]        stg_rdwe_i,
    input  logic [NSTAGE-1:0]        stg_rdrdy_i,
    input  logic [12*NSTAGE-1:0]     stg_csraddr_i,
    input  logic [XLEN*NSTAGE-1:0]   stg_csrdata_i,
    input  logic [NSTAGE-1:0]        stg_csrwe_i,
    input  logic                     heap_csrwe_i,
    input  logic [11:0]              heap_csraddr_i,
    input  logic [XLEN-1:0]          heap_csrdata_i,
    output logic [XLEN-1:0]          rs1_data_o,
    output logic [XLEN-1:0]          rs2_data_o,
    output logic [XLEN-1:0]          csr_data_o,
    output logic                     stall_o,
    output logic [7:0]               stall_cnt_o,
    output logic                     timeout_o,
    output logic                     heap_vld_o
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] STALL = 1'b1;

    localparam logic [7:0] STALL_LIMIT = 8'(STALL_MAX);

    logic             rs1_rdy;
    logic             rs2_rdy;
    logic             hazard;
    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [7:0]       cnt_nxt;

    // Select the youngest matching producer for each GPR source; x0 never forwards.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        rs1_data_o = rs1_data_i;
        rs2_data_o = rs2_data_i;
        rs1_rdy    = 1'b1;
        rs2_rdy    = 1'b1;
        // Walk oldest to youngest so the youngest match overwrites the rest.
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (stg_rdwe_i[i] && (stg_rdaddr_i[5*i +: 5] != 5'd0) &&
                (stg_rdaddr_i[5*i +: 5] == rs1_addr_i)) begin
                rs1_data_o = stg_rddata_i[XLEN*i +: XLEN];
                rs1_rdy    = stg_rdrdy_i[i];
            end
            if (stg_rdwe_i[i] && (stg_rdaddr_i[5*i +: 5] != 5'd0) &&
                (stg_rdaddr_i[5*i +: 5] == rs2_addr_i)) begin
                rs2_data_o = stg_rddata_i[XLEN*i +: XLEN];
                rs2_rdy    = stg_rdrdy_i[i];
            end
        end
    end

    // Only the selected producer's readiness matters: an older in-flight load
    // shadowed by a younger ready writer does not stall decode.
    assign hazard  = id_valid_i && (!rs1_rdy || !rs2_rdy);
    assign stall_o = hazard;

`ifdef HEAP_CSR_FWD_EN
    logic [11:0]     shadow_addr;
    logic [XLEN-1:0] shadow_data;
    logic            shadow_vld;

    // Heap shadow captures heap CSR updates; a wb-stage write to the same CSR
    // retires it, unless a new heap write lands in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_addr <= 12'd0;
            shadow_data <= '0;
            shadow_vld  <= 1'b0;
        end else if (heap_csrwe_i) begin
            shadow_addr <= heap_csraddr_i;
            shadow_data <= heap_csrdata_i;
            shadow_vld  <= 1'b1;
        end else if (stg_csrwe_i[NSTAGE-1] &&
                     (stg_csraddr_i[12*(NSTAGE-1) +: 12] == shadow_addr)) begin
            shadow_vld  <= 1'b0;
        end
    end

    assign heap_vld_o = shadow_vld;
`else
    logic heap_unused;

    assign heap_unused = ^{heap_csrwe_i, heap_csraddr_i, heap_csrdata_i};
    assign heap_vld_o  = 1'b0;
`endif

    // CSR read priority: youngest matching stage, then heap shadow, then CSR file.
    always_comb begin
        csr_data_o = csr_data_i;
`ifdef HEAP_CSR_FWD_EN
        if (shadow_vld && (shadow_addr == csr_addr_i)) begin
            csr_data_o = shadow_data;
        end
`endif
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (stg_csrwe_i[i] && (stg_csraddr_i[12*i +: 12] == csr_addr_i)) begin
                csr_data_o = stg_csrdata_i[XLEN*i +: XLEN];
            end
        end
    end

    // Stall FSM next state and saturating counter next value.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hazard)  state_nxt = STALL;
            STALL:   if (!hazard) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == STALL) begin
            cnt_nxt = (stall_cnt_o == 8'hFF) ? 8'hFF : stall_cnt_o + 8'd1;
        end else begin
            cnt_nxt = 8'd0;
        end
    end

    // State, stall counter and sticky timeout registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state       <= IDLE;
            stall_cnt_o <= 8'd0;
            timeout_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            stall_cnt_o <= cnt_nxt;
            if ((state_nxt == STALL) && (cnt_nxt == STALL_LIMIT)) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: table-driven forwarding vectors, hand-written stall,
// timeout, reset and heap-shadow sequences, then random stimulus against a
// behavioural reference model.
module tb_fwd_hazard_unit;

    localparam int XLEN      = 64;
    localparam int NSTAGE    = 3;
    localparam int STALL_MAX = 4;

`ifdef HEAP_CSR_FWD_EN
    localparam bit HEAP_EN = 1'b1;
`else
    localparam bit HEAP_EN = 1'b0;
`endif

    localparam logic [XLEN-1:0] RF1  = 64'h111;
    localparam logic [XLEN-1:0] RF2  = 64'h222;
    localparam logic [XLEN-1:0] CSRF = 64'h1234;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    id_valid;
    logic [4:0]              rs1_addr, rs2_addr;
    logic [XLEN-1:0]         rs1_data, rs2_data;
    logic [11:0]             csr_addr;
    logic [XLEN-1:0]         csr_data;
    logic [5*NSTAGE-1:0]     stg_rdaddr;
    logic [XLEN*NSTAGE-1:0]  stg_rddata;
    logic [NSTAGE-1:0]       stg_rdwe, stg_rdrdy;
    logic [12*NSTAGE-1:0]    stg_csraddr;
    logic [XLEN*NSTAGE-1:0]  stg_csrdata;
    logic [NSTAGE-1:0]       stg_csrwe;
    logic                    heap_csrwe;
    logic [11:0]             heap_csraddr;
    logic [XLEN-1:0]         heap_csrdata;
    logic [XLEN-1:0]         rs1_out, rs2_out, csr_out;
    logic                    stall, timeout, heap_vld;
    logic [7:0]              stall_cnt;

    // Per-stage stimulus kept as arrays for readability.
    logic [4:0]      s_addr [NSTAGE];
    logic [XLEN-1:0] s_data [NSTAGE];
    logic            s_we   [NSTAGE];
    logic            s_rdy  [NSTAGE];
    logic [11:0]     c_addr [NSTAGE];
    logic [XLEN-1:0] c_data [NSTAGE];
    logic            c_we   [NSTAGE];

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int              m_cnt;
    bit              m_to;
    bit              m_sv;
    logic [11:0]     m_sa;
    logic [XLEN-1:0] m_sd;

    typedef struct {
        string          name;
        logic           idv;
        logic [4:0]     r1;
        logic [4:0]     r2;
        logic [14:0]    a;    // {stage2, stage1, stage0} rd addresses
        logic [2:0]     we;
        logic [2:0]     rdy;
        logic [XLEN-1:0] e1;
        logic [XLEN-1:0] e2;
        logic           es;
    } vec_t;

    vec_t tbl [7];

    fwd_hazard_unit #(
        .XLEN      (XLEN),
        .NSTAGE    (NSTAGE),
        .STALL_MAX (STALL_MAX)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid_i     (id_valid),
        .rs1_addr_i     (rs1_addr),
        .rs2_addr_i     (rs2_addr),
        .rs1_data_i     (rs1_data),
        .rs2_data_i     (rs2_data),
        .csr_addr_i     (csr_addr),
        .csr_data_i     (csr_data),
        .stg_rdaddr_i   (stg_rdaddr),
        .stg_rddata_i   (stg_rddata),
        .stg_rdwe_i     (stg_rdwe),
        .stg_rdrdy_i    (stg_rdrdy),
        .stg_csraddr_i  (stg_csraddr),
        .stg_csrdata_i  (stg_csrdata),
        .stg_csrwe_i    (stg_csrwe),
        .heap_csrwe_i   (heap_csrwe),
        .heap_csraddr_i (heap_csraddr),
        .heap_csrdata_i (heap_csrdata),
        .rs1_data_o     (rs1_out),
        .rs2_data_o     (rs2_out),
        .csr_data_o     (csr_out),
        .stall_o        (stall),
        .stall_cnt_o    (stall_cnt),
        .timeout_o      (timeout),
        .heap_vld_o     (heap_vld)
    );

    always #5 clk = ~clk;

    // Pack the per-stage arrays onto the flat DUT buses.
    always_comb begin
        stg_rdaddr  = '0;
        stg_rddata  = '0;
        stg_rdwe    = '0;
        stg_rdrdy   = '0;
        stg_csraddr = '0;
        stg_csrdata = '0;
        stg_csrwe   = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            stg_rdaddr[5*i +: 5]        = s_addr[i];
            stg_rddata[XLEN*i +: XLEN]  = s_data[i];
            stg_rdwe[i]                 = s_we[i];
            stg_rdrdy[i]                = s_rdy[i];
            stg_csraddr[12*i +: 12]     = c_addr[i];
            stg_csrdata[XLEN*i +: XLEN] = c_data[i];
            stg_csrwe[i]                = c_we[i];
        end
    end

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_valid     = 1'b0;
        rs1_addr     = 5'd0;
        rs2_addr     = 5'd0;
        rs1_data     = RF1;
        rs2_data     = RF2;
        csr_addr     = 12'd0;
        csr_data     = CSRF;
        heap_csrwe   = 1'b0;
        heap_csraddr = 12'd0;
        heap_csrdata = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            s_addr[i] = 5'd0;
            s_we[i]   = 1'b0;
            s_rdy[i]  = 1'b1;
            c_addr[i] = 12'd0;
            c_data[i] = '0;
            c_we[i]   = 1'b0;
        end
        s_data[0] = 64'hA;
        s_data[1] = 64'hB;
        s_data[2] = 64'hC;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Reference: index of the youngest stage writing GPR a, or -1.
    function automatic int gpr_src(input logic [4:0] a);
        if (a == 5'd0) return -1;
        for (int i = 0; i < NSTAGE; i++) begin
            if (s_we[i] && s_addr[i] == a) return i;
        end
        return -1;
    endfunction

    function automatic int csr_src();
        for (int i = 0; i < NSTAGE; i++) begin
            if (c_we[i] && c_addr[i] == csr_addr) return i;
        end
        return -1;
    endfunction

    task automatic random_cycle(input int n);
        int k1, k2, kc;
        logic [XLEN-1:0] e1, e2, ec;
        bit hz;
        id_valid = ($urandom_range(0, 3) != 0);
        rs1_addr = 5'($urandom_range(0, 3));
        rs2_addr = 5'($urandom_range(0, 3));
        rs1_data = {$urandom(), $urandom()};
        rs2_data = {$urandom(), $urandom()};
        csr_addr = 12'h300 + 12'($urandom_range(0, 2));
        csr_data = {$urandom(), $urandom()};
        for (int i = 0; i < NSTAGE; i++) begin
            s_addr[i] = 5'($urandom_range(0, 3));
            s_we[i]   = 1'($urandom_range(0, 1));
            s_rdy[i]  = ($urandom_range(0, 3) != 0);
            s_data[i] = {$urandom(), $urandom()};
            c_addr[i] = 12'h300 + 12'($urandom_range(0, 2));
            c_we[i]   = ($urandom_range(0, 2) == 0);
            c_data[i] = {$urandom(), $urandom()};
        end
        heap_csrwe   = ($urandom_range(0, 3) == 0);
        heap_csraddr = 12'h300 + 12'($urandom_range(0, 2));
        heap_csrdata = {$urandom(), $urandom()};
        #1;
        k1 = gpr_src(rs1_addr);
        k2 = gpr_src(rs2_addr);
        kc = csr_src();
        e1 = rs1_data;
        if (k1 >= 0) e1 = s_data[k1];
        e2 = rs2_data;
        if (k2 >= 0) e2 = s_data[k2];
        ec = csr_data;
        if (kc >= 0) ec = c_data[kc];
        else if (HEAP_EN && m_sv && m_sa == csr_addr) ec = m_sd;
        hz = id_valid && ((k1 >= 0 && !s_rdy[k1]) || (k2 >= 0 && !s_rdy[k2]));
        check($sformatf("rnd%0d_rs1", n), rs1_out, e1);
        check($sformatf("rnd%0d_rs2", n), rs2_out, e2);
        check($sformatf("rnd%0d_csr", n), csr_out, ec);
        check($sformatf("rnd%0d_stall", n), 64'(stall), 64'(hz));
        check($sformatf("rnd%0d_cnt", n), 64'(stall_cnt), 64'(m_cnt));
        check($sformatf("rnd%0d_timeout", n), 64'(timeout), 64'(m_to));
        check($sformatf("rnd%0d_heap_vld", n), 64'(heap_vld), 64'(m_sv));
        // Advance the model to what the coming clock edge produces.
        if (hz) begin
            if (m_cnt + 1 == STALL_MAX) m_to = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end else begin
            m_cnt = 0;
        end
        if (HEAP_EN) begin
            if (heap_csrwe) begin
                m_sv = 1'b1;
                m_sa = heap_csraddr;
                m_sd = heap_csrdata;
            end else if (c_we[NSTAGE-1] && c_addr[NSTAGE-1] == m_sa) begin
                m_sv = 1'b0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #2;
        check("reset_cnt", 64'(stall_cnt), 64'd0);
        check("reset_timeout", 64'(timeout), 64'd0);
        check("reset_heap_vld", 64'(heap_vld), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- combinational forwarding table ----------------
        tbl[0] = '{name:"youngest_wins", idv:1'b1, r1:5'd5, r2:5'd1, a:{5'd5, 5'd0, 5'd5},
                   we:3'b101, rdy:3'b111, e1:64'hA, e2:RF2, es:1'b0};
        tbl[1] = '{name:"x0_regfile", idv:1'b1, r1:5'd3, r2:5'd0, a:{5'd0, 5'd0, 5'd0},
                   we:3'b001, rdy:3'b110, e1:RF1, e2:RF2, es:1'b0};
        tbl[2] = '{name:"hidden_older_load", idv:1'b1, r1:5'd5, r2:5'd1, a:{5'd5, 5'd0, 5'd5},
                   we:3'b101, rdy:3'b011, e1:64'hA, e2:RF2, es:1'b0};
        tbl[3] = '{name:"rs2_load_use", idv:1'b1, r1:5'd1, r2:5'd9, a:{5'd0, 5'd9, 5'd0},
                   we:3'b010, rdy:3'b101, e1:RF1, e2:64'hB, es:1'b1};
        tbl[4] = '{name:"no_valid_no_stall", idv:1'b0, r1:5'd1, r2:5'd9, a:{5'd0, 5'd9, 5'd0},
                   we:3'b010, rdy:3'b101, e1:RF1, e2:64'hB, es:1'b0};
        tbl[5] = '{name:"we_gates_match", idv:1'b1, r1:5'd4, r2:5'd2, a:{5'd0, 5'd4, 5'd4},
                   we:3'b010, rdy:3'b111, e1:64'hB, e2:RF2, es:1'b0};
        tbl[6] = '{name:"both_sources", idv:1'b1, r1:5'd6, r2:5'd7, a:{5'd6, 5'd0, 5'd7},
                   we:3'b101, rdy:3'b110, e1:64'hC, e2:64'hA, es:1'b1};

        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            clear_inputs();
            id_valid = tbl[k].idv;
            rs1_addr = tbl[k].r1;
            rs2_addr = tbl[k].r2;
            for (int i = 0; i < NSTAGE; i++) begin
                s_addr[i] = tbl[k].a[5*i +: 5];
                s_we[i]   = tbl[k].we[i];
                s_rdy[i]  = tbl[k].rdy[i];
            end
            #1;
            check($sformatf("tbl%0d_%s_rs1", k, tbl[k].name), rs1_out, tbl[k].e1);
            check($sformatf("tbl%0d_%s_rs2", k, tbl[k].name), rs2_out, tbl[k].e2);
            check($sformatf("tbl%0d_%s_stall", k, tbl[k].name), 64'(stall), 64'(tbl[k].es));
        end

        // ---------------- three-cycle load-use stall ----------------
        do_reset();
        @(negedge clk);
        id_valid  = 1'b1;
        rs1_addr  = 5'd7;
        s_addr[0] = 5'd7;
        s_we[0]   = 1'b1;
        s_rdy[0]  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall3_c%0d_stall", c), 64'(stall), 64'd1);
            check($sformatf("stall3_c%0d_cnt", c), 64'(stall_cnt), 64'(c));
            @(negedge clk);
        end
        s_rdy[0] = 1'b1;
        #1;
        check("stall3_release_stall", 64'(stall), 64'd0);
        check("stall3_release_cnt", 64'(stall_cnt), 64'd3);
        @(negedge clk);
        #1;
        check("stall3_idle_cnt", 64'(stall_cnt), 64'd0);
        check("stall3_no_timeout", 64'(timeout), 64'd0);

        // ---------------- timeout at STALL_MAX, sticky ----------------
        @(negedge clk);
        s_rdy[0] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("to_c%0d_cnt", c), 64'(stall_cnt), 64'(c));
            check($sformatf("to_c%0d_timeout", c), 64'(timeout), 64'(c >= STALL_MAX));
            @(negedge clk);
        end
        s_rdy[0] = 1'b1;
        #1;
        check("to_release_cnt", 64'(stall_cnt), 64'd6);
        @(negedge clk);
        #1;
        check("to_idle_cnt", 64'(stall_cnt), 64'd0);
        check("to_sticky", 64'(timeout), 64'd1);

        // ---------------- asynchronous reset mid-stall ----------------
        s_rdy[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_mid_pre_cnt", 64'(stall_cnt), 64'd2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cnt", 64'(stall_cnt), 64'd0);
        check("rst_mid_timeout", 64'(timeout), 64'd0);
        check("rst_mid_stall_comb", 64'(stall), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_rel_cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        #1;
        check("rst_rel_cnt_runs", 64'(stall_cnt), 64'd1);
        check("rst_rel_stall", 64'(stall), 64'd1);

        // ---------------- heap CSR shadow ----------------
        do_reset();
        @(negedge clk);
        heap_csrwe   = 1'b1;
        heap_csraddr = 12'h300;
        heap_csrdata = 64'h55;
        csr_addr     = 12'h300;
        #1;
        check("heap_preload_csr", csr_out, CSRF);
        check("heap_preload_vld", 64'(heap_vld), 64'd0);
        @(negedge clk);
        heap_csrwe = 1'b0;
        #1;
        check("heap_fwd_csr", csr_out, HEAP_EN ? 64'h55 : CSRF);
        check("heap_fwd_vld", 64'(heap_vld), 64'(HEAP_EN));
        csr_addr = 12'h301;
        #1;
        check("heap_addr_miss", csr_out, CSRF);
        csr_addr  = 12'h300;
        c_we[2]   = 1'b1;
        c_addr[2] = 12'h300;
        c_data[2] = 64'h77;
        #1;
        check("csr_stage_over_heap", csr_out, 64'h77);
        c_we[0]   = 1'b1;
        c_addr[0] = 12'h300;
        c_data[0] = 64'h99;
        #1;
        check("csr_youngest_stage", csr_out, 64'h99);
        c_we[0] = 1'b0;
        @(negedge clk);
        c_we[2] = 1'b0;
        #1;
        check("heap_wb_clear_vld", 64'(heap_vld), 64'd0);
        check("heap_wb_clear_csr", csr_out, CSRF);
        @(negedge clk);
        heap_csrwe   = 1'b1;
        heap_csrdata = 64'h66;
        @(negedge clk);
        heap_csrdata = 64'h67;
        c_we[2]      = 1'b1;
        #1;
        check("heap_reload_vld", 64'(heap_vld), 64'(HEAP_EN));
        @(negedge clk);
        heap_csrwe = 1'b0;
        c_we[2]    = 1'b0;
        #1;
        check("heap_write_wins_vld", 64'(heap_vld), 64'(HEAP_EN));
        check("heap_write_wins_csr", csr_out, HEAP_EN ? 64'h67 : CSRF);

        // ---------------- random stimulus vs. model ----------------
        do_reset();
        m_cnt = 0;
        m_to  = 1'b0;
        m_sv  = 1'b0;
        m_sa  = 12'd0;
        m_sd  = '0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            random_cycle(n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64: GPR/CSR data width.
REQ-002 SHALL have parameter NSTAGE, default 3: number of producer stages; index 0 is youngest (exe), NSTAGE-1 is oldest (wb).
REQ-003 SHALL have parameter STALL_MAX, default 8: stall-cycle limit before timeout, range 1..255.
REQ-004 SHALL have ports: clk in 1 (clock, all state on rising edge); rst_n in 1 (asynchronous, active-low reset).
REQ-005 SHALL have ports: id_valid_i in 1 (decode holds a valid instruction); rs1_addr_i, rs2_addr_i in 5 each; rs1_data_i, rs2_data_i in XLEN each (regfile read data).
REQ-006 SHALL have ports: csr_addr_i in 12; csr_data_i in XLEN (CSR file read data).
REQ-007 SHALL have ports: stg_rdaddr_i in 5*NSTAGE; stg_rddata_i in XLEN*NSTAGE; stg_rdwe_i in NSTAGE; stg_rdrdy_i in NSTAGE (1 = rd data valid this cycle; 0 = load in flight).
REQ-008 SHALL have ports: stg_csraddr_i in 12*NSTAGE; stg_csrdata_i in XLEN*NSTAGE; stg_csrwe_i in NSTAGE.
REQ-009 SHALL have ports: heap_csrwe_i in 1; heap_csraddr_i in 12; heap_csrdata_i in XLEN (heap unit CSR update).
REQ-010 SHALL have ports: rs1_data_o, rs2_data_o, csr_data_o out XLEN each; stall_o out 1; stall_cnt_o out 8; timeout_o out 1 (sticky); heap_vld_o out 1.

Function
REQ-011 For each GPR source, a stage SHALL match iff rdwe=1, rdaddr!=0, and rdaddr equals the source address.
REQ-012 GPR outputs SHALL be combinational, zero latency: data of the lowest-index matching stage, else the regfile value; source x0 always yields regfile data.
REQ-013 A CSR stage SHALL match iff csrwe=1 and csraddr equals csr_addr_i; csr_data_o priority: lowest-index matching stage, then valid heap shadow with equal address, then csr_data_i.
REQ-014 Hazard SHALL be id_valid_i AND (the selected, i.e. highest-priority, matching stage of rs1 or rs2 has rdrdy=0); a non-ready older stage hidden by a younger match is not a hazard.
REQ-015 stall_o SHALL equal the hazard combinationally.
REQ-016 FSM SHALL have states IDLE and STALL: IDLE->STALL on hazard; STALL->IDLE when hazard clears; STALL->STALL otherwise.
REQ-017 stall_cnt_o SHALL be 0 in IDLE, increment by 1 per clock in STALL, and saturate at 255; on STALL->IDLE it returns to 0 the following cycle.
REQ-018 timeout_o SHALL set on the edge where stall_cnt_o would reach STALL_MAX, and hold until reset.
REQ-019 Heap shadow (addr, data, valid) SHALL load heap_csraddr_i/heap_csrdata_i and set valid on clk when heap_csrwe_i=1; heap_vld_o = valid.
REQ-020 Shadow valid SHALL clear when stg_csrwe_i[NSTAGE-1]=1 and its address equals the shadow address, unless heap_csrwe_i=1 in the same cycle, in which case the new heap write wins.

Reset
REQ-021 rst_n=0 SHALL immediately force FSM to IDLE, stall_cnt_o=0, timeout_o=0, shadow valid=0, shadow addr/data=0, independent of clk.
REQ-022 Reset mid-stall SHALL drop the counter to 0; stall_o remains purely combinational and asserts again after reset if the hazard persists.

Configuration
REQ-023 Macro HEAP_CSR_FWD_EN SHALL gate the heap shadow path.
REQ-024 With HEAP_CSR_FWD_EN defined, REQ-019/020 apply; without it, no shadow registers exist, heap ports are ignored, heap_vld_o ties to 0, and CSR priority omits the heap step.

Verification
REQ-025 rs1=5; stage0 and stage2 both write x5 (0xA, 0xC), rdrdy=1 -> rs1_data_o=0xA, stall_o=0.
REQ-026 rs2=0; stage0 writes x0 with 0xFF -> rs2_data_o=rs2_data_i.
REQ-027 rs1=7; stage0 writes x7, rdrdy=0 for 3 cycles -> stall_o=1 for 3 cycles, stall_cnt_o 0,1,2,3, then 0 after rdrdy=1.
REQ-028 STALL_MAX=4; hazard held 6 cycles -> timeout_o=1 from the 4th edge, stays 1 after hazard clears; rst_n low mid-stall clears counter and timeout_o.
REQ-029 Heap write 0x300 <- 0x55, then csr_addr_i=0x300 with no stage match -> csr_data_o=0x55; wb stage writes 0x300 -> heap_vld_o=0 next cycle; same cycle with heap write -> heap_vld_o stays 1.
REQ-030 Build without HEAP_CSR_FWD_EN: repeat REQ-029 -> csr_data_o=csr_data_i, heap_vld_o=0.
